// File: rtl/serdes_pkg.sv
// Shared widths, uio bit positions and output-enable constant for the serdes loopback core.
// Latency: n/a (constants only).
// Backpressure: n/a.
package serdes_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  // Bit positions inside uio_out
  localparam int RXV = 0;
  localparam int TXD = 1;
  localparam int TXB = 2;
  localparam int PAR = 3;

  localparam logic [7:0] UIO_OE_VAL = 8'h0F;

endpackage

// File: rtl/serdes_shift_reg.sv
// Shift register with clear/load/shift and an up or down bit counter.
// Latency: 1 cycle from control inputs to dat/cnt; nxt is the combinational shifted value.
// Backpressure: none; shift is simply not asserted to hold state.
import serdes_pkg::*;

module serdes_shift_reg #(
  parameter int W          = BYTE_W,
  parameter int CW         = CNT_W,
  parameter bit SHIFT_LEFT = 1'b1,
  parameter bit CNT_UP     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  load_dat,
  input  logic [CW-1:0] load_cnt,
  input  logic          shift,
  input  logic          sin,
  output logic [W-1:0]  dat,
  output logic [W-1:0]  nxt,
  output logic [CW-1:0] cnt
);

  // Value the register takes on a shift; exported so the owner can capture a
  // completed word on the same edge it is formed.
  assign nxt = SHIFT_LEFT ? {dat[W-2:0], sin} : {sin, dat[W-1:1]};

  // Clear beats load, load beats shift.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dat <= '0;
      cnt <= '0;
    end else if (load) begin
      dat <= load_dat;
      cnt <= load_cnt;
    end else if (shift) begin
      dat <= nxt;
      cnt <= CNT_UP ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_serdes.sv
// Byte-framed serial loopback: deserialize ui_in[0] to uo_out, re-serialize each byte MSB first on uio_out[1].
// Latency: byte on uo_out and rx_valid the cycle after its 8th bit edge; tx MSB visible that same cycle.
// Backpressure: none; ena=0 freezes state, a new byte reloads the transmitter. Optional macro SERDES_PARITY_EN.
import serdes_pkg::*;

module tt_um_serdes #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic                din;
  logic                resync;
  logic                rx_shift;
  logic                rx_done;
  logic [BYTE_W-1:0]   rx_shreg;
  logic [BYTE_W-1:0]   rx_nxt;
  logic [CNT_W-1:0]    rx_cnt;
  logic [BYTE_W-1:0]   rx_byte;
  logic                rx_valid;
  logic [BYTE_W-1:0]   tx_shreg;
  logic [CNT_W:0]      tx_cnt;
  logic                tx_busy;
  logic                tx_shift;
  logic [BYTE_W-1:0]   unused_tx_nxt;
  logic [BYTE_W-1:0]   unused_rx_shreg;
  logic                unused_pins;
  logic                par;

  assign din    = ui_in[0];
  assign resync = ui_in[1];

  // Resync outranks ena for the receiver; the transmitter is left alone.
  assign rx_shift = ena && !resync;
  assign rx_done  = rx_shift && (rx_cnt == CNT_W'(BYTE_W - 1));
  assign tx_busy  = (tx_cnt != '0);
  assign tx_shift = ena && tx_busy;

  serdes_shift_reg #(
    .W          (BYTE_W),
    .CW         (CNT_W),
    .SHIFT_LEFT (MSB_FIRST != 0),
    .CNT_UP     (1'b1)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .clr      (resync),
    .load     (1'b0),
    .load_dat ('0),
    .load_cnt ('0),
    .shift    (rx_shift),
    .sin      (din),
    .dat      (rx_shreg),
    .nxt      (rx_nxt),
    .cnt      (rx_cnt)
  );

  // Load on completion wins over shifting, giving a gapless tx stream.
  serdes_shift_reg #(
    .W          (BYTE_W),
    .CW         (CNT_W + 1),
    .SHIFT_LEFT (1'b1),
    .CNT_UP     (1'b0)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (rx_done),
    .load_dat (rx_nxt),
    .load_cnt ((CNT_W + 1)'(BYTE_W)),
    .shift    (tx_shift),
    .sin      (1'b0),
    .dat      (tx_shreg),
    .nxt      (unused_tx_nxt),
    .cnt      (tx_cnt)
  );

  // Capture the completed byte and pulse rx_valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      if (rx_done) begin
        rx_byte <= rx_nxt;
      end
    end
  end

`ifdef SERDES_PARITY_EN
  // Even parity tracks rx_byte, registered on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (rx_done) begin
      par <= ^rx_nxt;
    end
  end
`else
  assign par = 1'b0;
`endif

  // Pack status bits into uio_out; upper nibble stays zero.
  always_comb begin
    uio_out      = '0;
    uio_out[RXV] = rx_valid;
    uio_out[TXD] = tx_shreg[BYTE_W-1];
    uio_out[TXB] = tx_busy;
    uio_out[PAR] = par;
  end

  assign uo_out = rx_byte;
  assign uio_oe = UIO_OE_VAL;

  assign unused_rx_shreg = rx_shreg;
  assign unused_pins     = ^{uio_in, ui_in[7:2], unused_rx_shreg, unused_tx_nxt};

endmodule

// File: tb/tb_tt_um_serdes.sv
module tb_tt_um_serdes;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       mon_par;

  always #5 clk = ~clk;

  tt_um_serdes dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Scoreboard: every rx_valid pops the next expected byte.
  always @(negedge clk) begin
    if (uio_out[0] === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rx_valid_spurious: uo_out=%h with no byte expected", uo_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (uo_out !== mon_exp) begin
          fails++;
          $display("FAIL rx_byte: got %h expected %h", uo_out, mon_exp);
        end
`ifdef SERDES_PARITY_EN
        mon_par = ^mon_exp;
`else
        mon_par = 1'b0;
`endif
        tests++;
        if (uio_out[3] !== mon_par) begin
          fails++;
          $display("FAIL parity: got %b expected %b for byte %h", uio_out[3], mon_par, mon_exp);
        end
      end
    end
  end

  // Apply one clock edge with the given inputs; returns 1ns after the edge.
  task automatic cyc(input logic e, input logic d, input logic rs, input logic r);
    logic [5:0] junk;
    junk   = 6'($urandom);
    ena    = e;
    rst    = r;
    ui_in  = {junk, rs, d};
    uio_in = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) cyc(1'b1, b[i], 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    send_bits(b, 7, 0);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    tests++;
    if (uo_out !== 8'h00) begin fails++; $display("FAIL reset_uo_out: got %h expected 00", uo_out); end
    tests++;
    if (uio_out !== 8'h00) begin fails++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
    tests++;
    if (uio_oe !== 8'h0F) begin fails++; $display("FAIL reset_uio_oe: got %h expected 0F", uio_oe); end
  endtask

  task automatic test_rx;
    logic [7:0] b;
    b = 8'hAA;
    send_byte(b);
    tests++;
    if (uo_out !== 8'hAA) begin fails++; $display("FAIL rx_aa: got %h expected AA", uo_out); end
    tests++;
    if (uio_out[0] !== 1'b1) begin fails++; $display("FAIL rx_valid_pulse: got %b expected 1", uio_out[0]); end
  endtask

  task automatic test_tx;
    logic [7:0] b;
    b = 8'hAA;
    // MSB visible right after completion
    tests++;
    if (uio_out[2:1] !== {1'b1, b[7]}) begin
      fails++; $display("FAIL tx_bit7: busy/txd got %b expected %b", uio_out[2:1], {1'b1, b[7]});
    end
    for (int k = 1; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      tests++;
      if (uio_out[2:0] !== {1'b1, b[7-k], 1'b0}) begin
        fails++; $display("FAIL tx_bit%0d: busy/txd/rxv got %b expected %b", 7 - k, uio_out[2:0], {1'b1, b[7-k], 1'b0});
      end
    end
    // Resync with ena low keeps the receiver from completing a byte; tx holds
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (uio_out[2] !== 1'b1) begin fails++; $display("FAIL tx_hold: busy got %b expected 1", uio_out[2]); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (uio_out[2:1] !== 2'b00) begin fails++; $display("FAIL tx_idle: busy/txd got %b expected 00", uio_out[2:1]); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_gating_resync;
    logic [7:0] b;
    b = 8'h3C;
    exp_q.push_back(b);
    send_bits(b, 7, 5);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
    tests++;
    if (uo_out !== 8'hAA || uio_out[0] !== 1'b0) begin
      fails++; $display("FAIL ena_hold: uo_out=%h rxv=%b expected AA/0", uo_out, uio_out[0]);
    end
    send_bits(b, 4, 0);
    tests++;
    if (uo_out !== 8'h3C) begin fails++; $display("FAIL gated_byte: got %h expected 3C", uo_out); end
    // resync with ena high
    send_bits(8'hFF, 7, 5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    send_byte(8'h81);
    tests++;
    if (uo_out !== 8'h81) begin fails++; $display("FAIL resync_ena1: got %h expected 81", uo_out); end
    // resync with ena low
    send_bits(8'hFF, 7, 5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h42);
    tests++;
    if (uo_out !== 8'h42) begin fails++; $display("FAIL resync_ena0: got %h expected 42", uo_out); end
  endtask

  task automatic test_reset_mid_byte;
    send_bits(8'hFF, 7, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    tests++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      fails++; $display("FAIL mid_reset: uo_out=%h uio_out=%h expected 00/00", uo_out, uio_out);
    end
    send_byte(8'h5A);
    tests++;
    if (uo_out !== 8'h5A) begin fails++; $display("FAIL after_reset_byte: got %h expected 5A", uo_out); end
  endtask

  task automatic test_parity;
    logic exp_p;
    send_byte(8'h07);
`ifdef SERDES_PARITY_EN
    exp_p = 1'b1;
`else
    exp_p = 1'b0;
`endif
    tests++;
    if (uio_out[3] !== exp_p) begin fails++; $display("FAIL parity_07: got %b expected %b", uio_out[3], exp_p); end
    send_byte(8'h03);
    tests++;
    if (uio_out[3] !== 1'b0) begin fails++; $display("FAIL parity_03: got %b expected 0", uio_out[3]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[4];
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) bytes[j] = 8'($urandom);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(bytes[j]);
      for (int i = 7; i >= 0; i--) begin
        if (j > 0) begin
          tests++;
          if (uio_out[2:1] !== {1'b1, bytes[j-1][i]}) begin
            fails++;
            $display("FAIL b2b_tx byte%0d bit%0d: busy/txd got %b expected %b", j - 1, i, uio_out[2:1], {1'b1, bytes[j-1][i]});
          end
        end
        cyc(1'b1, bytes[j][i], 1'b0, 1'b0);
      end
    end
    tests++;
    if (uo_out !== bytes[3]) begin fails++; $display("FAIL b2b_last: got %h expected %h", uo_out, bytes[3]); end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset;
    test_rx;
    test_tx;
    test_gating_resync;
    test_reset_mid_byte;
    test_parity;
    test_back_to_back;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d bytes never reported, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
